// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences R-type, LW, SW, BEQ, ADDI and J over a
// shared memory and a single ALU. It drives the datapath selects, enables and aluop,
// handshakes with memory (mem_req/mem_ready), and traps illegal opcodes and memory
// timeouts.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   op[5:0]      opcode from the instruction register
//   zero         ALU zero flag (qualifies branch)
//   mem_ready    memory accepts/completes the current access this cycle
//   mem_req      memory request; mem_we selects write (1) or read (0)
//   iord         address select: 0=PC, 1=ALUOut
//   ir_write     load instruction register
//   pc_en        PC load enable = pc_write | (branch & zero)
//   pc_src[1:0]  00=ALU result, 01=ALUOut, 10=jump target
//   alu_src_a    0=PC, 1=rs
//   alu_src_b    00=rt, 01=4, 10=signext imm, 11=signext imm<<2
//   aluop[1:0]   00=add, 01=sub, 10=funct-decoded
//   reg_write, reg_dst, mem_to_reg   register file write controls
//   instr_done   pulse in the last cycle of each instruction
//   illegal_op   sticky: unknown opcode decoded
//   bus_err      sticky: memory timeout, FSM halted until reset
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_HALT   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [TMO_W-1:0] CNT_MAX = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] CNT_TMO = TMO_W'(MEM_TIMEOUT);
  localparam bit               TMO_EN  = (MEM_TIMEOUT != 0);

  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [TMO_W-1:0] wait_cnt;
  logic             pc_write;
  logic             branch;
  logic             in_wait;
  logic             timeout;
  logic             set_illegal;
  logic             set_bus_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Memory wait counter; restarts on every state change and saturates if untimed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (in_wait && !mem_ready && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + TMO_W'(1);
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      if (set_illegal) illegal_op <= 1'b1;
      if (set_bus_err) bus_err    <= 1'b1;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    aluop       = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    in_wait     = 1'b0;
    // mem_ready arriving in the expiry cycle takes priority over the timeout
    timeout     = TMO_EN && !mem_ready && (wait_cnt == CNT_TMO);

    case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        in_wait   = 1'b1;
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next  = S_HALT;
          set_bus_err = 1'b1;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            state_next  = S_FETCH;
            set_illegal = 1'b1;
            instr_done  = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        in_wait = 1'b1;
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (timeout) begin
          state_next  = S_HALT;
          set_bus_err = 1'b1;
        end
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        in_wait    = 1'b1;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) begin
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next  = S_HALT;
          set_bus_err = 1'b1;
        end
      end

      S_EXEC: begin
        alu_src_a  = 1'b1;
        aluop      = 2'b10;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        aluop      = 2'b01;
        pc_src     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end

      S_HALT: state_next = S_HALT;

      default: state_next = S_IDLE;
    endcase

    pc_en = pc_write | (branch & zero);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by
// cycle and compares the full control vector against hand-built expectations.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b, aluop;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, instr_done;
  logic       illegal_op, bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit ill_exp  = 1'b0;
  bit berr_exp = 1'b0;

  multicycle_controller #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                aluop, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op, bus_err};

  // Control vector without the two sticky flags
  function automatic logic [15:0] v(input bit req, input bit we, input bit io,
                                    input bit irw, input bit pce, input bit [1:0] pcs,
                                    input bit a, input bit [1:0] b, input bit [1:0] alu,
                                    input bit rw, input bit rd, input bit m2r,
                                    input bit done);
    return {req, we, io, irw, pce, pcs, a, b, alu, rw, rd, m2r, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle at the falling edge, then advance past the next rising edge
  task automatic step(input string tag, input logic [15:0] e);
    @(negedge clk);
    check(tag, 32'(obs), 32'({e, ill_exp, berr_exp}));
    @(posedge clk);
    #1;
  endtask

  logic [15:0] e_zero, e_fetch_r, e_fetch_w, e_decode, e_memadr, e_memrd, e_memwb;
  logic [15:0] e_memwr_w, e_memwr_r, e_exec, e_aluwb, e_br_t, e_br_nt, e_addiex;
  logic [15:0] e_addiwb, e_jump, e_dec_ill;

  initial begin
    //              req we io irw pce pcs   a  b     alu   rw rd m2r done
    e_zero    = v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    e_fetch_r = v(1, 0, 0, 1, 1, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    e_fetch_w = v(1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    e_decode  = v(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 0);
    e_dec_ill = v(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 1);
    e_memadr  = v(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0);
    e_memrd   = v(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    e_memwb   = v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1, 1);
    e_memwr_w = v(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    e_memwr_r = v(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    e_exec    = v(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0);
    e_aluwb   = v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 0, 1);
    e_br_t    = v(0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 1);
    e_br_nt   = v(0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 1);
    e_addiex  = v(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0);
    e_addiwb  = v(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 1);
    e_jump    = v(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 1);

    rst_n = 1'b0; op = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
    #3;
    check("reset", 32'(obs), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle", e_zero);

    // LW, zero-wait: 5 cycles
    step("lw_fetch", e_fetch_r);
    step("lw_decode", e_decode);
    step("lw_memadr", e_memadr);
    step("lw_memrd", e_memrd);
    step("lw_memwb", e_memwb);

    // SW with 3 wait cycles in MEMWR
    op = 6'b101011;
    step("sw_fetch", e_fetch_r);
    step("sw_decode", e_decode);
    step("sw_memadr", e_memadr);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("sw_memwr_wait", e_memwr_w);
    mem_ready = 1'b1;
    step("sw_memwr_done", e_memwr_r);

    // R-type
    op = 6'b000000;
    step("r_fetch", e_fetch_r);
    step("r_decode", e_decode);
    step("r_exec", e_exec);
    step("r_aluwb", e_aluwb);

    // ADDI
    op = 6'b001000;
    step("addi_fetch", e_fetch_r);
    step("addi_decode", e_decode);
    step("addi_ex", e_addiex);
    step("addi_wb", e_addiwb);

    // BEQ taken then not taken
    op = 6'b000100; zero = 1'b1;
    step("beq_t_fetch", e_fetch_r);
    step("beq_t_decode", e_decode);
    step("beq_t_branch", e_br_t);
    zero = 1'b0;
    step("beq_nt_fetch", e_fetch_r);
    step("beq_nt_decode", e_decode);
    step("beq_nt_branch", e_br_nt);

    // J
    op = 6'b000010;
    step("j_fetch", e_fetch_r);
    step("j_decode", e_decode);
    step("j_jump", e_jump);

    // Illegal opcode returns to FETCH and sets the sticky flag
    op = 6'b111111;
    step("ill_fetch", e_fetch_r);
    step("ill_decode", e_dec_ill);
    ill_exp = 1'b1;
    op = 6'b000000;
    step("ill_r_fetch", e_fetch_r);
    step("ill_r_decode", e_decode);
    step("ill_r_exec", e_exec);
    step("ill_r_aluwb", e_aluwb);

    // Reset clears illegal_op
    rst_n = 1'b0;
    #1;
    ill_exp = 1'b0;
    check("rst_clear_ill", 32'(obs), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle2", e_zero);

    // Timeout: 5 FETCH wait cycles then HALT with bus_err
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) step("tmo_fetch_wait", e_fetch_w);
    berr_exp = 1'b1;
    step("halt", e_zero);
    mem_ready = 1'b1;
    step("halt_hold", e_zero);
    step("halt_hold2", e_zero);

    // Reset clears bus_err; restart
    rst_n = 1'b0;
    #1;
    berr_exp = 1'b0;
    check("rst_clear_berr", 32'(obs), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle3", e_zero);
    mem_ready = 1'b0;
    step("fetch_wait", e_fetch_w);

    // Async reset mid-access drops mem_req without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_drop_req", 32'(mem_req), 32'd0);
    check("async_all_zero", 32'(obs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
